ufp_dot3_seq: RTL and testbench

//  Sequential unsigned fixed-point 3-component dot product, out = a.x*b.x + a.y*b.y + a.z*b.z.

---
 rtl/ufp_dot3_seq.sv | 117 +++++++++++
 tb/tb_ufp_dot3_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufp_dot3_seq.sv
// ufp_dot3_seq: sequential unsigned fixed-point 3-component dot product.
//   out = a.x*b.x + a.y*b.y + a.z*b.z, every value UQ(IW).(QW).
//   A single multiplier is time-shared over the three components. Partial
//   products are accumulated into a W+2 bit register, so a sum overflow can
//   be told apart from a wrapped result.
// Ports (W = IW+QW):
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   a, b [3*W]          operand vectors {z,y,x}, with x in [W-1:0]
//   out_valid/out_ready result handshake
//   out [W]             registered result, held until the next result
//   clipping            the result overflowed; qualified by out_valid
module ufp_dot3_seq #(
  parameter int IW   = 16,
  parameter int QW   = 16,
  parameter bit CLIP = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3*(IW+QW)-1:0]      a,
  input  logic [3*(IW+QW)-1:0]      b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IW+QW-1:0]          out,
  output logic                      clipping
);
  localparam int W = IW + QW;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state, state_nx;
  logic [1:0]     idx;
  logic [3*W-1:0] a_q, b_q;
  logic [W+1:0]   acc, acc_nx;
  logic           ovf, ovf_nx, ovf_tot;
  logic [W-1:0]   opa, opb;
  logic [2*W-1:0] prod;
  logic           unused_frac;

  // component select for the shared multiplier
  always_comb begin
    opa = a_q[W-1:0];
    opb = b_q[W-1:0];
    case (idx)
      2'd1:    begin opa = a_q[2*W-1:W];   opb = b_q[2*W-1:W];   end
      2'd2:    begin opa = a_q[3*W-1:2*W]; opb = b_q[3*W-1:2*W]; end
      default: ;
    endcase
  end

  assign prod        = {{W{1'b0}}, opa} * {{W{1'b0}}, opb};
  // fraction bits below QW are truncated away (round toward zero)
  assign unused_frac = ^prod[QW-1:0];
  assign acc_nx      = acc + {2'b00, prod[W+QW-1:QW]};
  assign ovf_nx      = ovf | (|prod[2*W-1:W+QW]);
  // overflow of the final sum shows up in the two guard bits of acc
  assign ovf_tot     = ovf_nx | (|acc_nx[W+1:W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = MUL;
      end
      MUL:  if (idx == 2'd2) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      idx      <= 2'd0;
      out      <= '0;
      clipping <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          acc <= '0;
          ovf <= 1'b0;
          idx <= 2'd0;
        end
        MUL: begin
          acc <= acc_nx;
          ovf <= ovf_nx;
          idx <= idx + 2'd1;
          // last component: register the final result on the way into DONE
          if (idx == 2'd2) begin
            idx      <= 2'd0;
            out      <= (CLIP && ovf_tot) ? {W{1'b1}} : acc_nx[W-1:0];
            clipping <= ovf_tot;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ufp_dot3_seq.sv
// Testbench for ufp_dot3_seq: two instances (CLIP=0 and CLIP=1) share the
// same stimulus; results are compared against an arithmetic reference model.
module tb_ufp_dot3_seq;
  localparam int IW = 16;
  localparam int QW = 16;
  localparam int W  = IW + QW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, out_ready;
  logic [3*W-1:0] a, b;
  logic           in_ready0, in_ready1, ov0, ov1, clip0, clip1;
  logic [W-1:0]   out0, out1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ufp_dot3_seq #(.IW(IW), .QW(QW), .CLIP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready),
    .out(out0), .clipping(clip0));

  ufp_dot3_seq #(.IW(IW), .QW(QW), .CLIP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
    .out(out1), .clipping(clip1));

  // Reference: exact integer products, truncated to QW fraction bits, summed
  // without bound; overflow if any product or the sum needs more than W bits.
  function automatic void model(input logic [3*W-1:0] av, input logic [3*W-1:0] bv,
                                input bit clip, output logic [W-1:0] o, output logic c);
    longint unsigned sum, x, y, p;
    bit ov;
    sum = 0;
    ov  = 0;
    for (int i = 0; i < 3; i++) begin
      x = 64'(av[i*W +: W]);
      y = 64'(bv[i*W +: W]);
      p = x * y;
      if ((p >> (W + QW)) != 0) ov = 1;
      sum += (p >> QW) & ((64'd1 << W) - 1);
    end
    if (sum >= (64'd1 << W)) ov = 1;
    c = ov;
    o = (clip && ov) ? {W{1'b1}} : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'($urandom_range(0, 32'h0004_0000));
      2:       return W'($urandom_range(0, 32'h0100_0000));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [3*W-1:0] rvec();
    return {rnd_op(), rnd_op(), rnd_op()};
  endfunction

  // Called at a negedge with both DUTs idle; returns at a negedge, idle again.
  task automatic run_op(input logic [3*W-1:0] av, input logic [3*W-1:0] bv, input int hold);
    logic [W-1:0] e0, e1;
    logic         ec0, ec1;
    int           lat;
    model(av, bv, 1'b0, e0, ec0);
    model(av, bv, 1'b1, e1, ec1);
    n_cmp++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      n_bad++; $display("FAIL op_in_ready: got %b/%b want 1", in_ready0, in_ready1);
    end
    a = av; b = bv; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0; a = rvec(); b = rvec();
    lat = 1;
    while (ov0 !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 4 || ov1 !== 1'b1) begin
      n_bad++; $display("FAIL op_latency: got %0d cycles (ov1=%b) want 4", lat, ov1);
    end
    n_cmp++;
    if (out0 !== e0 || clip0 !== ec0) begin
      n_bad++; $display("FAIL op_wrap: a=%h b=%h got %h/%b want %h/%b", av, bv, out0, clip0, e0, ec0);
    end
    n_cmp++;
    if (out1 !== e1 || clip1 !== ec1) begin
      n_bad++; $display("FAIL op_clip: a=%h b=%h got %h/%b want %h/%b", av, bv, out1, clip1, e1, ec1);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0]; a = rvec(); b = rvec();
      @(negedge clk);
      n_cmp++;
      if (ov0 !== 1'b1 || ov1 !== 1'b1 || in_ready0 !== 1'b0 || in_ready1 !== 1'b0 ||
          out0 !== e0 || out1 !== e1 || clip0 !== ec0 || clip1 !== ec1) begin
        n_bad++;
        $display("FAIL hold: cycle %0d got v=%b%b r=%b%b out=%h/%h want v=11 r=00 out=%h/%h",
                 h, ov0, ov1, in_ready0, in_ready1, out0, out1, e0, e1);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || in_ready0 !== 1'b1 || in_ready1 !== 1'b1 ||
        out0 !== e0 || out1 !== e1) begin
      n_bad++;
      $display("FAIL drain: got v=%b%b r=%b%b out=%h/%h want v=00 r=11 out=%h/%h",
               ov0, ov1, in_ready0, in_ready1, out0, out1, e0, e1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    n_cmp++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || out0 !== '0 || out1 !== '0 || clip0 !== 1'b0 || clip1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: v=%b%b out=%h/%h clip=%b%b want zeros", ov0, ov1, out0, out1, clip0, clip1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: r=%b%b v=%b%b want r=11 v=00", in_ready0, in_ready1, ov0, ov1);
    end
  endtask

  task automatic test_directed;
    logic [3*W-1:0] da[6], db[6];
    logic [W-1:0]   w0[6], w1[6];
    logic           wc[6];
    da = '{{32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
           {32'h0, 32'h0, 32'h0100_0000},
           {32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
           {32'h0, 32'h0, 32'h0000_8000},
           {32'h0, 32'h0, 32'h0001_8000},
           {32'h0, 32'h0, 32'h0}};
    db = '{{32'h0006_0000, 32'h0005_0000, 32'h0004_0000},
           {32'h0, 32'h0, 32'h0100_0000},
           {32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
           {32'h0, 32'h0, 32'h0000_0001},
           {32'h0, 32'h0, 32'h0001_8000},
           {32'hFFFF_FFFF, 32'h1234_5678, 32'h0}};
    w0 = '{32'h0020_0000, 32'h0, 32'h8000_0000, 32'h0, 32'h0002_4000, 32'h0};
    w1 = '{32'h0020_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0002_4000, 32'h0};
    wc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(da[i], db[i], 0);
      n_cmp++;
      if (out0 !== w0[i] || out1 !== w1[i] || clip0 !== wc[i] || clip1 !== wc[i]) begin
        n_bad++;
        $display("FAIL directed_%0d: got %h/%b %h/%b want %h/%b %h/%b",
                 i, out0, clip0, out1, clip1, w0[i], wc[i], w1[i], wc[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    run_op({32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
           {32'h0006_0000, 32'h0005_0000, 32'h0004_0000}, 5);
    run_op({32'h0, 32'h0, 32'h0100_0000}, {32'h0, 32'h0, 32'h0100_0000}, 5);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) run_op(rvec(), rvec(), $urandom_range(0, 3));
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q0[$], q1[$];
    logic         qc0[$], qc1[$];
    int           hs[$];
    logic [W-1:0] e0, e1;
    logic         c0, c1;
    int           n;
    bit           timeout;
    n = 0; timeout = 1;
    out_ready = 1'b1; in_valid = 1'b1; a = rvec(); b = rvec();
    for (int c = 0; c < 60; c++) begin
      if (ov0 === 1'b1) begin
        n_cmp++;
        if (q0.size() == 0 || ov1 !== 1'b1 || out0 !== q0[0] || clip0 !== qc0[0] ||
            out1 !== q1[0] || clip1 !== qc1[0]) begin
          n_bad++;
          $display("FAIL b2b_result: got %h/%b %h/%b (pending %0d)", out0, clip0, out1, clip1, q0.size());
        end
        if (q0.size() > 0) begin
          void'(q0.pop_front()); void'(q1.pop_front());
          void'(qc0.pop_front()); void'(qc1.pop_front());
        end
      end
      if (in_ready0 === 1'b1 && in_valid) begin
        model(a, b, 1'b0, e0, c0);
        model(a, b, 1'b1, e1, c1);
        q0.push_back(e0); qc0.push_back(c0); q1.push_back(e1); qc1.push_back(c1);
        hs.push_back(cyc);
        n++;
      end
      if (n == 4 && q0.size() == 0) begin
        timeout = 0;
        break;
      end
      @(negedge clk);
      if (n >= 4) in_valid = 1'b0;
      a = rvec(); b = rvec();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (timeout || n != 4) begin
      n_bad++; $display("FAIL b2b_timeout: issued %0d pending %0d want 4 issued 0 pending", n, q0.size());
    end
    for (int i = 1; i < hs.size(); i++) begin
      n_cmp++;
      if (hs[i] - hs[i-1] != 5) begin
        n_bad++; $display("FAIL b2b_interval: got %0d want 5", hs[i] - hs[i-1]);
      end
    end
  endtask

  task automatic test_reset_midop;
    bit bad;
    // abort during MUL (cycle t+2)
    a = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    b = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000};
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || out0 !== '0 || out1 !== '0 || clip0 !== 1'b0 || clip1 !== 1'b0) begin
      n_bad++; $display("FAIL rst_mul: v=%b%b out=%h/%h clip=%b%b want zeros", ov0, ov1, out0, out1, clip0, clip1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov0 !== 1'b0 || ov1 !== 1'b0 || in_ready0 !== 1'b1 || in_ready1 !== 1'b1) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL rst_stale: got stale valid or low ready after abort, want v=00 r=11");
    end
    // abort during DONE while the result is held
    a = {32'h0, 32'h0, 32'h0100_0000};
    b = {32'h0, 32'h0, 32'h0100_0000};
    out_ready = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ov0 !== 1'b1 || clip0 !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre_done: v=%b clip=%b want 1/1", ov0, clip0);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || out1 !== '0 || clip0 !== 1'b0 || clip1 !== 1'b0) begin
      n_bad++; $display("FAIL rst_done: v=%b%b out1=%h clip=%b%b want zeros", ov0, ov1, out1, clip0, clip1);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    run_op({32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
           {32'h0006_0000, 32'h0005_0000, 32'h0004_0000}, 0);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_random;
    test_back_to_back;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
